// File: rtl/gpu_pkg.sv
// Shared GPU definitions used by the OBM DMA engine and its bus interface.
//   VRAM_ADDR_WIDTH : width of a VRAM byte address
//   OBM_BASE_ADDR   : VRAM address of object memory byte 0
//   OBM_BYTES       : size of object memory in bytes
//   dma_state_t     : OBM DMA engine states
package gpu_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 12;
  localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE_ADDR = 12'h800;
  localparam int unsigned OBM_BYTES = 256;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    RUN
  } dma_state_t;

endpackage

// File: rtl/obm_dma_if.sv
// Bus bundle of the OBM DMA engine.
//   CPU side    : reg_we, reg_data (trigger), cpu_halt, busy, done, overrun
//   video side  : vblank
//   source read : mem_addr, mem_re, mem_data (data one cycle after mem_re)
//   VRAM write  : vram_address, data_out, write_enable, SELECT_obm
// master = the DMA engine, slave = the surrounding system.
interface obm_dma_if;
  import gpu_pkg::*;

  logic                       reg_we;
  logic [7:0]                 reg_data;
  logic                       vblank;
  logic [15:0]                mem_addr;
  logic                       mem_re;
  logic [7:0]                 mem_data;
  logic [VRAM_ADDR_WIDTH-1:0] vram_address;
  logic [7:0]                 data_out;
  logic                       write_enable;
  logic                       SELECT_obm;
  logic                       cpu_halt;
  logic                       busy;
  logic                       done;
  logic                       overrun;

  modport master (
    input  reg_we, reg_data, vblank, mem_data,
    output mem_addr, mem_re, vram_address, data_out, write_enable, SELECT_obm,
    output cpu_halt, busy, done, overrun
  );

  modport slave (
    output reg_we, reg_data, vblank, mem_data,
    input  mem_addr, mem_re, vram_address, data_out, write_enable, SELECT_obm,
    input  cpu_halt, busy, done, overrun
  );

endinterface

// File: rtl/obm_dma_edge_detect.sv
// Rising-edge detector with a configurable reset value for the delayed copy.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   d_i    : level input
//   rise_o : high in the cycle where d_i is high and was low the cycle before
module edge_detect_m #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q, d_d;

  always_comb d_d = d_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= ResetVal;
    end else begin
      d_q <= d_d;
    end
  end

  always_comb rise_o = d_i & ~d_q;

endmodule

// File: rtl/obm_dma.sv
// OBM DMA: copies a 256-byte CPU page into object memory, halting the CPU while it runs.
//   cpu_clk : the only clock
//   rst     : synchronous active-high reset
//   bus     : obm_dma_if master (trigger, vblank, source read, VRAM write, status)
// Read and write phases overlap: the byte read at idx is written at idx+1.
module obm_dma
  import gpu_pkg::*;
#(
  parameter bit                         SYNC_TO_VBLANK = 1'b1,
  parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE       = OBM_BASE_ADDR
) (
  input  logic      cpu_clk,
  input  logic      rst,
  obm_dma_if.master bus
);

  dma_state_t  state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        vblank_rise;
  logic [8:0]  wr_off;

  // Reset value 1 so a vblank already high out of reset is not taken as an edge.
  edge_detect_m #(
    .ResetVal(1'b1)
  ) u_vblank_edge (
    .clk_i (cpu_clk),
    .rst_i (rst),
    .d_i   (bus.vblank),
    .rise_o(vblank_rise)
  );

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      page_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    page_d    = page_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (bus.reg_we) begin
          page_d    = bus.reg_data;
          overrun_d = 1'b0;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (!SYNC_TO_VBLANK || vblank_rise) begin
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        idx_d = idx_q + 9'd1;
        // idx == 256 carries only the final write.
        if (idx_q == 9'(OBM_BYTES)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Includes the exit cycle of RUN: the trigger is still dropped there.
    if (bus.reg_we && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    wr_off           = idx_q - 9'd1;
    bus.mem_re       = 1'b0;
    bus.mem_addr     = '0;
    bus.write_enable = 1'b0;
    bus.vram_address = '0;
    bus.data_out     = '0;
    bus.cpu_halt     = 1'b0;
    if (state_q == RUN) begin
      bus.cpu_halt = 1'b1;
      if (!idx_q[8]) begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {page_q, idx_q[7:0]};
      end
      if (idx_q != 9'd0) begin
        bus.write_enable = 1'b1;
        bus.vram_address = OBM_BASE + VRAM_ADDR_WIDTH'(wr_off);
        bus.data_out     = bus.mem_data;
      end
    end
    bus.SELECT_obm = bus.write_enable;
    bus.busy       = (state_q != IDLE);
    bus.done       = done_q;
    bus.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_obm_dma.sv
// Self-checking bench for obm_dma: dut0 copies immediately, dut1 waits for vblank.
module tb_obm_dma;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   copy_id = 0;
  int   stamp0[256];
  int   stamp1[256];
  wr_t  q0[$];
  wr_t  q1[$];

  obm_dma_if if0 ();
  obm_dma_if if1 ();

  obm_dma #(.SYNC_TO_VBLANK(1'b0)) u_dut0 (.cpu_clk(clk), .rst(rst), .bus(if0));
  obm_dma #(.SYNC_TO_VBLANK(1'b1)) u_dut1 (.cpu_clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Source memory contents: page 0x02 holds its own low address byte.
  function automatic logic [7:0] src(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h02;
  endfunction

  always @(posedge clk) if (if0.mem_re) if0.mem_data <= src(if0.mem_addr);
  always @(posedge clk) if (if1.mem_re) if1.mem_data <= src(if1.mem_addr);

  // Advance to the next falling edge and retire any VRAM write against the scoreboard.
  task automatic sb_tick();
    wr_t e;
    @(negedge clk);
    if (if0.write_enable) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_extra_write got addr=%h data=%h required no write",
                 if0.vram_address, if0.data_out);
      end else begin
        e = q0.pop_front();
        if ({if0.vram_address, if0.data_out, if0.SELECT_obm} !== {e.addr, e.data, 1'b1}) begin
          errors++;
          $display("FAIL sb0_write got addr=%h data=%h sel=%b required addr=%h data=%h sel=1",
                   if0.vram_address, if0.data_out, if0.SELECT_obm, e.addr, e.data);
        end
      end
      stamp0[if0.vram_address[7:0]] = copy_id;
    end
    if (if1.write_enable) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_extra_write got addr=%h data=%h required no write",
                 if1.vram_address, if1.data_out);
      end else begin
        e = q1.pop_front();
        if ({if1.vram_address, if1.data_out, if1.SELECT_obm} !== {e.addr, e.data, 1'b1}) begin
          errors++;
          $display("FAIL sb1_write got addr=%h data=%h sel=%b required addr=%h data=%h sel=1",
                   if1.vram_address, if1.data_out, if1.SELECT_obm, e.addr, e.data);
        end
      end
      stamp1[if1.vram_address[7:0]] = copy_id;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) sb_tick();
    checks++;
    if ({if0.mem_addr, if0.mem_re, if0.vram_address, if0.data_out, if0.write_enable,
         if0.SELECT_obm, if0.cpu_halt, if0.busy, if0.done, if0.overrun} !== 44'd0) begin
      errors++;
      $display("FAIL reset_dut0 got re=%b we=%b halt=%b busy=%b done=%b ovr=%b required all 0",
               if0.mem_re, if0.write_enable, if0.cpu_halt, if0.busy, if0.done, if0.overrun);
    end
    checks++;
    if ({if1.mem_addr, if1.mem_re, if1.vram_address, if1.data_out, if1.write_enable,
         if1.SELECT_obm, if1.cpu_halt, if1.busy, if1.done, if1.overrun} !== 44'd0) begin
      errors++;
      $display("FAIL reset_dut1 got re=%b we=%b halt=%b busy=%b done=%b ovr=%b required all 0",
               if1.mem_re, if1.write_enable, if1.cpu_halt, if1.busy, if1.done, if1.overrun);
    end
    rst = 1'b0;
    sb_tick();
  endtask

  task automatic test_copy_nosync();
    logic [4:0] exp_v, got_v;
    int halt_n = 0;
    int bad = 0;
    copy_id++;
    sb_tick();
    if0.reg_we = 1'b1;
    if0.reg_data = 8'h02;
    for (int k = 0; k < 256; k++) q0.push_back({12'h800 + 12'(k), src({8'h02, 8'(k)})});
    for (int k = 1; k <= 262; k++) begin
      sb_tick();
      if0.reg_we = 1'b0;
      exp_v = {(k >= 2 && k <= 257), (k >= 3 && k <= 258), (k >= 2 && k <= 258),
               (k == 259), (k >= 1 && k <= 258)};
      got_v = {if0.mem_re, if0.write_enable, if0.cpu_halt, if0.done, if0.busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL copy_timing T+%0d got re/we/halt/done/busy=%b required %b",
                 k, got_v, exp_v);
      end
      if (if0.mem_re) begin
        checks++;
        if (if0.mem_addr !== {8'h02, 8'(k - 2)}) begin
          errors++;
          $display("FAIL copy_rd_addr T+%0d got %h required %h", k, if0.mem_addr,
                   {8'h02, 8'(k - 2)});
        end
      end
      if (if0.cpu_halt) halt_n++;
    end
    checks++;
    if (halt_n != 257) begin
      errors++;
      $display("FAIL copy_halt_cycles got %0d required 257", halt_n);
    end
    for (int k = 0; k < 256; k++) if (stamp0[k] != copy_id) bad++;
    checks++;
    if (bad != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL copy_coverage got %0d unwritten, %0d pending required 0 and 0",
               bad, q0.size());
    end
  endtask

  task automatic test_overrun();
    for (int rep = 0; rep < 2; rep++) begin
      copy_id++;
      sb_tick();
      if0.reg_we = 1'b1;
      if0.reg_data = 8'h02;
      for (int k = 0; k < 256; k++) q0.push_back({12'h800 + 12'(k), src({8'h02, 8'(k)})});
      for (int k = 1; k <= 261; k++) begin
        sb_tick();
        if0.reg_we = 1'b0;
        if (k == 1) begin
          checks++;
          if (if0.overrun !== 1'b0 || if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept rep%0d got ovr=%b busy=%b required ovr=0 busy=1",
                     rep, if0.overrun, if0.busy);
          end
        end
        if (rep == 0 && k == 50) begin
          if0.reg_we = 1'b1;
          if0.reg_data = 8'h03;
        end
        if (rep == 1 && k == 258) begin
          if0.reg_we = 1'b1;
          if0.reg_data = 8'h05;
        end
        if (rep == 0 && k == 51) begin
          checks++;
          if (if0.overrun !== 1'b1 || if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_midrun got ovr=%b busy=%b required ovr=1 busy=1",
                     if0.overrun, if0.busy);
          end
        end
        if (rep == 0 && if0.mem_re) begin
          checks++;
          if (if0.mem_addr[15:8] !== 8'h02) begin
            errors++;
            $display("FAIL ovr_page T+%0d got %h required 02", k, if0.mem_addr[15:8]);
          end
        end
        if (rep == 1 && k == 259) begin
          checks++;
          if ({if0.overrun, if0.done, if0.busy} !== 3'b110) begin
            errors++;
            $display("FAIL ovr_exit got ovr/done/busy=%b required 110",
                     {if0.overrun, if0.done, if0.busy});
          end
        end
        if (rep == 1 && k == 261) begin
          checks++;
          if (if0.busy !== 1'b0 || if0.mem_re !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ignored got busy=%b re=%b required 0 0", if0.busy, if0.mem_re);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    int dones = 0;
    copy_id++;
    sb_tick();
    if0.reg_we = 1'b1;
    if0.reg_data = 8'h02;
    for (int k = 0; k < 99; k++) q0.push_back({12'h800 + 12'(k), src({8'h02, 8'(k)})});
    for (int k = 1; k <= 101; k++) begin
      sb_tick();
      if0.reg_we = 1'b0;
    end
    rst = 1'b1;
    sb_tick();
    checks++;
    if ({if0.mem_addr, if0.mem_re, if0.vram_address, if0.data_out, if0.write_enable,
         if0.SELECT_obm, if0.cpu_halt, if0.busy, if0.done, if0.overrun} !== 44'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got re=%b we=%b halt=%b busy=%b done=%b required all 0",
               if0.mem_re, if0.write_enable, if0.cpu_halt, if0.busy, if0.done);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sb_tick();
      if (if0.done || if0.write_enable || if0.cpu_halt) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet got %0d active cycles required 0", dones);
    end
    for (int k = 0; k < 256; k++) begin
      if ((k < 99) != (stamp0[k] == copy_id)) bad++;
    end
    checks++;
    if (bad != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_obm got %0d wrong bytes, %0d pending required 0 and 0",
               bad, q0.size());
    end
  endtask

  task automatic test_page_ff();
    int zero_hits = 0;
    copy_id++;
    sb_tick();
    if0.reg_we = 1'b1;
    if0.reg_data = 8'hFF;
    for (int k = 0; k < 256; k++) q0.push_back({12'h800 + 12'(k), src({8'hFF, 8'(k)})});
    for (int k = 1; k <= 260; k++) begin
      sb_tick();
      if0.reg_we = 1'b0;
      if (if0.mem_re && if0.mem_addr == 16'h0000) zero_hits++;
      if (k == 257) begin
        checks++;
        if (if0.mem_re !== 1'b1 || if0.mem_addr !== 16'hFFFF) begin
          errors++;
          $display("FAIL ff_last_read got re=%b addr=%h required re=1 addr=ffff",
                   if0.mem_re, if0.mem_addr);
        end
      end
      if (k == 258) begin
        checks++;
        if (if0.write_enable !== 1'b1 || if0.mem_re !== 1'b0 || if0.vram_address !== 12'h8FF)
        begin
          errors++;
          $display("FAIL ff_last_write got we=%b re=%b addr=%h required we=1 re=0 addr=8ff",
                   if0.write_enable, if0.mem_re, if0.vram_address);
        end
      end
    end
    checks++;
    if (zero_hits != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL ff_wrap got %0d reads of 0000, %0d pending required 0 and 0",
               zero_hits, q0.size());
    end
  endtask

  // case 0: trigger with vblank low, vblank falls mid-copy; case 1: trigger with vblank high.
  task automatic test_vblank_sync();
    for (int c = 0; c < 2; c++) begin
      int done_at = 0;
      int done_n = 0;
      int bad = 0;
      logic [7:0] pg;
      pg = (c == 0) ? 8'h02 : 8'h07;
      copy_id++;
      if1.vblank = (c == 1);
      repeat (3) sb_tick();
      if1.reg_we = 1'b1;
      if1.reg_data = pg;
      for (int k = 0; k < 256; k++) q1.push_back({12'h800 + 12'(k), src({pg, 8'(k)})});
      for (int k = 1; k <= 10; k++) begin
        sb_tick();
        if1.reg_we = 1'b0;
        if (c == 1 && k == 6) if1.vblank = 1'b0;
        checks++;
        if ({if1.busy, if1.mem_re, if1.cpu_halt} !== 3'b100) begin
          errors++;
          $display("FAIL sync%0d_wait cyc %0d got busy/re/halt=%b required 100",
                   c, k, {if1.busy, if1.mem_re, if1.cpu_halt});
        end
      end
      if1.vblank = 1'b1;
      sb_tick();
      checks++;
      if (if1.mem_re !== 1'b1 || if1.cpu_halt !== 1'b1 || if1.mem_addr !== {pg, 8'h00}) begin
        errors++;
        $display("FAIL sync%0d_start got re=%b halt=%b addr=%h required re=1 halt=1 addr=%h",
                 c, if1.mem_re, if1.cpu_halt, if1.mem_addr, {pg, 8'h00});
      end
      for (int j = 2; j <= 262; j++) begin
        sb_tick();
        if (c == 0 && j == 50) if1.vblank = 1'b0;
        if (if1.done) begin
          done_n++;
          done_at = j;
        end
      end
      checks++;
      if (done_n != 1 || done_at != 258) begin
        errors++;
        $display("FAIL sync%0d_done got %0d pulses at E+%0d required 1 at E+258",
                 c, done_n, done_at);
      end
      for (int k = 0; k < 256; k++) if (stamp1[k] != copy_id) bad++;
      checks++;
      if (bad != 0 || q1.size() != 0) begin
        errors++;
        $display("FAIL sync%0d_coverage got %0d unwritten, %0d pending required 0 and 0",
                 c, bad, q1.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.reg_we = 1'b0;
    if0.reg_data = 8'h00;
    if0.vblank = 1'b0;
    if1.reg_we = 1'b0;
    if1.reg_data = 8'h00;
    if1.vblank = 1'b0;
    test_reset();
    test_copy_nosync();
    test_overrun();
    test_reset_mid_run();
    test_page_ff();
    test_vblank_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
